// File: rtl/secded_scrub_ctrl_if.sv
// Host and memory bus bundle for the SECDED scrub controller.
// slave is the controller's view; master is the host/memory environment's view.
interface secded_scrub_ctrl_if #(
    parameter int ADDR_W = 6
);
    logic              i_host_req;
    logic              i_host_we;
    logic [ADDR_W-1:0] i_host_addr;
    logic [7:0]        i_host_wdata;
    logic              o_host_gnt;
    logic              o_mem_en;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [7:0]        o_mem_wdata;
    logic [7:0]        i_mem_rdata;

    modport slave (
        input  i_host_req,
        input  i_host_we,
        input  i_host_addr,
        input  i_host_wdata,
        input  i_mem_rdata,
        output o_host_gnt,
        output o_mem_en,
        output o_mem_we,
        output o_mem_addr,
        output o_mem_wdata
    );

    modport master (
        output i_host_req,
        output i_host_we,
        output i_host_addr,
        output i_host_wdata,
        output i_mem_rdata,
        input  o_host_gnt,
        input  o_mem_en,
        input  o_mem_we,
        input  o_mem_addr,
        input  o_mem_wdata
    );
endinterface

// File: rtl/secded_scrub_ctrl.sv
// Background SECDED scrubber sharing a single-port memory with a host that always wins.
// Each step reads one word, fixes single-bit errors by write-back and logs double errors.
module secded_scrub_ctrl #(
    parameter int ADDR_W     = 6,
    parameter int INTERVAL_W = 16,
    parameter int CNT_W      = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_scrub_en,
    input  logic [INTERVAL_W-1:0] i_interval,
    secded_scrub_ctrl_if.slave    bus,
    output logic [CNT_W-1:0]      o_ce_cnt,
    output logic [CNT_W-1:0]      o_ue_cnt,
    output logic                  o_ue_irq,
    output logic [ADDR_W-1:0]     o_ue_addr,
    output logic                  o_pass_done,
    output logic                  o_busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WAIT = 3'd2,
        CHK  = 3'd3,
        WB   = 3'd4
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;

    logic [INTERVAL_W-1:0]   timer_reg;
    logic                    timer_load_reg;
    logic [ADDR_W-1:0]       scrub_addr_reg;
    logic [7:0]              data_reg;
    logic                    hazard_reg;
    logic [CNT_W-1:0]        ce_cnt_reg;
    logic [CNT_W-1:0]        ue_cnt_reg;
    logic                    ue_irq_reg;
    logic [ADDR_W-1:0]       ue_addr_reg;

    logic [2:0]              syndrome;
    logic                    parity;
    logic                    word_clean;
    logic                    word_correctable;
    logic [7:0]              corr_word;
    logic                    host_wr_hit;
    logic                    in_window;
    logic                    cancel;

    logic                    advance;
    logic                    do_ce;
    logic                    do_ue;
    logic                    scrub_rd;
    logic                    scrub_wr;
    logic                    scrub_go;

    // Syndrome and overall parity of the captured word
    assign syndrome[0] = data_reg[0] ^ data_reg[2] ^ data_reg[4] ^ data_reg[6];
    assign syndrome[1] = data_reg[1] ^ data_reg[2] ^ data_reg[5] ^ data_reg[6];
    assign syndrome[2] = data_reg[3] ^ data_reg[4] ^ data_reg[5] ^ data_reg[6];
    assign parity      = ^data_reg;

    assign word_clean       = (syndrome == 3'd0) && !parity;
    assign word_correctable = parity;

    // A zero syndrome with odd parity means the overall parity bit itself flipped
    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_fix
            assign corr_word[gi] = data_reg[gi] ^ (syndrome == 3'(gi + 1));
        end
    endgenerate
    assign corr_word[7] = data_reg[7] ^ (syndrome == 3'd0);

    assign host_wr_hit = bus.i_host_req && bus.i_host_we &&
                         (bus.i_host_addr == scrub_addr_reg);
    assign in_window   = (state_reg == WAIT) || (state_reg == CHK) || (state_reg == WB);
    assign cancel      = hazard_reg || (in_window && host_wr_hit);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and step actions
    always_comb begin
        state_next = state_reg;
        advance    = 1'b0;
        do_ce      = 1'b0;
        do_ue      = 1'b0;
        scrub_rd   = 1'b0;
        scrub_wr   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!timer_load_reg && i_scrub_en && (timer_reg == '0)) begin
                    state_next = RD;
                end
            end
            RD: begin
                if (!bus.i_host_req) begin
                    scrub_rd   = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                state_next = CHK;
            end
            CHK: begin
                // A host write to this word makes the read stale: drop the whole step
                if (cancel || word_clean) begin
                    advance = 1'b1;
                end else if (word_correctable) begin
                    state_next = WB;
                end else begin
                    do_ue   = 1'b1;
                    advance = 1'b1;
                end
            end
            WB: begin
                if (cancel) begin
                    advance = 1'b1;
                end else if (!bus.i_host_req) begin
                    scrub_wr = 1'b1;
                    do_ce    = 1'b1;
                    advance  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (advance) begin
            state_next = IDLE;
        end
    end

    // Port mux and status outputs; the scrubber never drives the port during reset
    always_comb begin
        scrub_go          = (scrub_rd || scrub_wr) && !i_rst;
        bus.o_host_gnt    = bus.i_host_req;
        bus.o_mem_en      = 1'b0;
        bus.o_mem_we      = 1'b0;
        bus.o_mem_addr    = '0;
        bus.o_mem_wdata   = '0;
        if (bus.i_host_req) begin
            bus.o_mem_en    = 1'b1;
            bus.o_mem_we    = bus.i_host_we;
            bus.o_mem_addr  = bus.i_host_addr;
            bus.o_mem_wdata = bus.i_host_wdata;
        end else if (scrub_go) begin
            bus.o_mem_en    = 1'b1;
            bus.o_mem_we    = scrub_wr;
            bus.o_mem_addr  = scrub_addr_reg;
            bus.o_mem_wdata = corr_word;
        end
        o_pass_done = advance && (scrub_addr_reg == LAST_ADDR) && !i_rst;
        o_busy      = (state_reg != IDLE) && !i_rst;
        o_ce_cnt    = ce_cnt_reg;
        o_ue_cnt    = ue_cnt_reg;
        o_ue_irq    = ue_irq_reg;
        o_ue_addr   = ue_addr_reg;
    end

    // Datapath: timer, scrub pointer, captured word, hazard flag and error log
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            timer_reg      <= '0;
            timer_load_reg <= 1'b1;
            scrub_addr_reg <= '0;
            data_reg       <= '0;
            hazard_reg     <= 1'b0;
            ce_cnt_reg     <= '0;
            ue_cnt_reg     <= '0;
            ue_irq_reg     <= 1'b0;
            ue_addr_reg    <= '0;
        end else begin
            ue_irq_reg <= do_ue;

            if (state_reg == IDLE) begin
                if (timer_load_reg) begin
                    timer_reg      <= i_interval;
                    timer_load_reg <= 1'b0;
                end else if (i_scrub_en && (timer_reg != '0)) begin
                    timer_reg <= timer_reg - INTERVAL_W'(1);
                end
            end

            if (state_reg == WAIT) begin
                data_reg <= bus.i_mem_rdata;
            end

            if (advance) begin
                timer_reg      <= i_interval;
                scrub_addr_reg <= scrub_addr_reg + ADDR_W'(1);
                hazard_reg     <= 1'b0;
            end else if (in_window && host_wr_hit) begin
                hazard_reg <= 1'b1;
            end

            if (do_ce && (ce_cnt_reg != CNT_MAX)) begin
                ce_cnt_reg <= ce_cnt_reg + CNT_W'(1);
            end

            if (do_ue) begin
                ue_addr_reg <= scrub_addr_reg;
                if (ue_cnt_reg != CNT_MAX) begin
                    ue_cnt_reg <= ue_cnt_reg + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_secded_scrub_ctrl.sv
// Directed bench for secded_scrub_ctrl with a behavioural single-port memory.
// Each scenario task drives its own stimulus and checks hand-computed codewords.
module tb_secded_scrub_ctrl;

    localparam int ADDR_W     = 6;
    localparam int INTERVAL_W = 16;
    localparam int CNT_W      = 8;
    localparam int DEPTH      = 64;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  scrub_en;
    logic [INTERVAL_W-1:0] interval;
    logic [CNT_W-1:0]      ce_cnt;
    logic [CNT_W-1:0]      ue_cnt;
    logic                  ue_irq;
    logic [ADDR_W-1:0]     ue_addr;
    logic                  pass_done;
    logic                  busy;

    secded_scrub_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    secded_scrub_ctrl #(
        .ADDR_W    (ADDR_W),
        .INTERVAL_W(INTERVAL_W),
        .CNT_W     (CNT_W)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_scrub_en (scrub_en),
        .i_interval (interval),
        .bus        (bus),
        .o_ce_cnt   (ce_cnt),
        .o_ue_cnt   (ue_cnt),
        .o_ue_irq   (ue_irq),
        .o_ue_addr  (ue_addr),
        .o_pass_done(pass_done),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory model: registered read, plus a backdoor load port owned by the same process
    logic [7:0]        mem [DEPTH];
    logic              bd_we = 1'b0;
    logic [ADDR_W-1:0] bd_addr = '0;
    logic [7:0]        bd_data = '0;

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        if (bus.o_mem_en) begin
            bus.i_mem_rdata <= mem[bus.o_mem_addr];
            if (bus.o_mem_we) mem[bus.o_mem_addr] <= bus.o_mem_wdata;
        end
    end

    int                scrub_reads  = 0;
    int                scrub_writes = 0;
    int                pass_cnt     = 0;
    int                irq_cnt      = 0;
    logic [ADDR_W-1:0] last_waddr   = '0;
    logic [7:0]        last_wdata   = '0;

    always @(posedge clk) begin
        if (bus.o_mem_en && !bus.i_host_req) begin
            if (bus.o_mem_we) begin
                scrub_writes <= scrub_writes + 1;
                last_waddr   <= bus.o_mem_addr;
                last_wdata   <= bus.o_mem_wdata;
            end else begin
                scrub_reads <= scrub_reads + 1;
            end
        end
        if (pass_done) pass_cnt <= pass_cnt + 1;
        if (ue_irq)    irq_cnt  <= irq_cnt + 1;
    end

    // Clean background codewords: 0x00, 0xFF and 0x55 (encoding of 4'hB)
    function automatic logic [7:0] clean_word(input int a);
        case (a % 3)
            0:       return 8'h00;
            1:       return 8'hFF;
            default: return 8'h55;
        endcase
    endfunction

    task automatic poke(input int a, input logic [7:0] d);
        bd_addr = ADDR_W'(a);
        bd_data = d;
        bd_we   = 1'b1;
        @(posedge clk);
        #1;
        bd_we   = 1'b0;
    endtask

    // Leaves reset asserted; caller releases it after any extra pokes
    task automatic apply_reset(input logic [INTERVAL_W-1:0] iv);
        @(posedge clk);
        #1;
        rst              = 1'b1;
        scrub_en         = 1'b0;
        interval         = iv;
        bus.i_host_req   = 1'b0;
        bus.i_host_we    = 1'b0;
        bus.i_host_addr  = '0;
        bus.i_host_wdata = '0;
        for (int a = 0; a < DEPTH; a++) poke(a, clean_word(a));
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst      = 1'b0;
        scrub_en = 1'b1;
    endtask

    task automatic wait_pass(input int budget);
        int start;
        bool_loop: begin
            start = pass_cnt;
            for (int i = 0; i < budget; i++) begin
                @(negedge clk);
                if (pass_cnt != start) disable bool_loop;
            end
        end
        checks++;
        if (pass_cnt == start) begin
            errors++;
            $display("FAIL pass_timeout: no o_pass_done within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        apply_reset(16'd2);
        bus.i_host_req = 1'b0;
        @(negedge clk);
        checks++;
        if (ce_cnt !== 8'd0 || ue_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_counters: ce=%0d ue=%0d expected 0 0", ce_cnt, ue_cnt);
        end
        checks++;
        if (ue_irq !== 1'b0 || ue_addr !== 6'd0 || pass_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: irq=%0b ue_addr=%0d pass=%0b expected 0 0 0", ue_irq, ue_addr, pass_done);
        end
        checks++;
        if (busy !== 1'b0 || bus.o_mem_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_port: busy=%0b mem_en=%0b expected 0 0", busy, bus.o_mem_en);
        end
        release_reset();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_cycle_idle: busy=%0b expected 0", busy);
        end
        $display("test_reset: done");
    endtask

    task automatic test_clean_pass();
        int r0, r1, r2, w0, q0;
        apply_reset(16'd2);
        release_reset();
        r0 = scrub_reads; w0 = scrub_writes; q0 = irq_cnt;
        wait_pass(2000);
        r1 = scrub_reads;
        wait_pass(2000);
        r2 = scrub_reads;
        checks++;
        if (r1 - r0 != 64) begin
            errors++;
            $display("FAIL clean_first_pass_reads: got %0d expected 64", r1 - r0);
        end
        checks++;
        if (r2 - r1 != 64) begin
            errors++;
            $display("FAIL clean_second_pass_reads: got %0d expected 64", r2 - r1);
        end
        checks++;
        if (scrub_writes != w0) begin
            errors++;
            $display("FAIL clean_no_writes: got %0d writes expected 0", scrub_writes - w0);
        end
        checks++;
        if (ce_cnt !== 8'd0 || ue_cnt !== 8'd0 || irq_cnt != q0) begin
            errors++;
            $display("FAIL clean_counters: ce=%0d ue=%0d irqs=%0d expected 0 0 0", ce_cnt, ue_cnt, irq_cnt - q0);
        end
        $display("test_clean_pass: reads %0d/%0d", r1 - r0, r2 - r1);
    endtask

    task automatic test_single_ce();
        int w0, q0;
        apply_reset(16'd2);
        poke(5, 8'h51);
        release_reset();
        w0 = scrub_writes; q0 = irq_cnt;
        wait_pass(2000);
        checks++;
        if (scrub_writes - w0 != 1 || last_waddr !== 6'd5 || last_wdata !== 8'h55) begin
            errors++;
            $display("FAIL ce_writeback: writes=%0d addr=%0d data=%h expected 1 5 55",
                     scrub_writes - w0, last_waddr, last_wdata);
        end
        checks++;
        if (mem[5] !== 8'h55) begin
            errors++;
            $display("FAIL ce_mem_word5: got %h expected 55", mem[5]);
        end
        checks++;
        if (ce_cnt !== 8'd1 || ue_cnt !== 8'd0 || irq_cnt != q0) begin
            errors++;
            $display("FAIL ce_counters: ce=%0d ue=%0d irqs=%0d expected 1 0 0", ce_cnt, ue_cnt, irq_cnt - q0);
        end
        $display("test_single_ce: ce=%0d", ce_cnt);
    endtask

    task automatic test_double_ue();
        int w0, q0;
        apply_reset(16'd2);
        poke(9, 8'hDD);
        release_reset();
        w0 = scrub_writes; q0 = irq_cnt;
        wait_pass(2000);
        checks++;
        if (scrub_writes != w0 || mem[9] !== 8'hDD) begin
            errors++;
            $display("FAIL ue_no_write: writes=%0d word9=%h expected 0 dd", scrub_writes - w0, mem[9]);
        end
        checks++;
        if (ue_cnt !== 8'd1 || ce_cnt !== 8'd0) begin
            errors++;
            $display("FAIL ue_counters: ue=%0d ce=%0d expected 1 0", ue_cnt, ce_cnt);
        end
        checks++;
        if (irq_cnt - q0 != 1) begin
            errors++;
            $display("FAIL ue_irq_pulses: got %0d expected 1", irq_cnt - q0);
        end
        checks++;
        if (ue_addr !== 6'd9) begin
            errors++;
            $display("FAIL ue_addr: got %0d expected 9", ue_addr);
        end
        $display("test_double_ue: ue=%0d addr=%0d", ue_cnt, ue_addr);
    endtask

    task automatic test_overall_parity();
        int w0;
        apply_reset(16'd2);
        poke(3, 8'h9E);
        release_reset();
        w0 = scrub_writes;
        wait_pass(2000);
        checks++;
        if (scrub_writes - w0 != 1 || last_waddr !== 6'd3 || mem[3] !== 8'h1E) begin
            errors++;
            $display("FAIL parity_writeback: writes=%0d addr=%0d word3=%h expected 1 3 1e",
                     scrub_writes - w0, last_waddr, mem[3]);
        end
        checks++;
        if (ce_cnt !== 8'd1) begin
            errors++;
            $display("FAIL parity_ce_cnt: got %0d expected 1", ce_cnt);
        end
        $display("test_overall_parity: word3=%h", mem[3]);
    endtask

    task automatic hold_host(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            checks++;
            if (bus.o_mem_en !== 1'b1 || bus.o_mem_we !== 1'b0 ||
                bus.o_mem_addr !== 6'd40 || bus.o_host_gnt !== 1'b1) begin
                errors++;
                $display("FAIL %s_host_owns_port: en=%0b we=%0b addr=%0d gnt=%0b expected 1 0 40 1",
                         tag, bus.o_mem_en, bus.o_mem_we, bus.o_mem_addr, bus.o_host_gnt);
            end
        end
    endtask

    task automatic test_host_stall();
        int r0, w0;
        bit got;
        apply_reset(16'd0);
        poke(0, 8'hB5);
        release_reset();
        bus.i_host_req  = 1'b1;
        bus.i_host_we   = 1'b0;
        bus.i_host_addr = 6'd40;
        r0 = scrub_reads; w0 = scrub_writes;
        hold_host(20, "stall_rd");
        checks++;
        if (busy !== 1'b1 || scrub_reads != r0) begin
            errors++;
            $display("FAIL stall_rd_held: busy=%0b reads=%0d expected 1 0", busy, scrub_reads - r0);
        end
        @(posedge clk); #1; bus.i_host_req = 1'b0;
        @(posedge clk); #1; bus.i_host_req = 1'b1;
        hold_host(20, "stall_wb");
        checks++;
        if (busy !== 1'b1 || scrub_reads - r0 != 1 || scrub_writes != w0) begin
            errors++;
            $display("FAIL stall_wb_held: busy=%0b reads=%0d writes=%0d expected 1 1 0",
                     busy, scrub_reads - r0, scrub_writes - w0);
        end
        @(posedge clk); #1; bus.i_host_req = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (scrub_writes != w0) got = 1'b1;
        end
        checks++;
        if (!got || last_waddr !== 6'd0 || last_wdata !== 8'hB4 || ce_cnt !== 8'd1) begin
            errors++;
            $display("FAIL stall_completion: wrote=%0b addr=%0d data=%h ce=%0d expected 1 0 b4 1",
                     got, last_waddr, last_wdata, ce_cnt);
        end
        $display("test_host_stall: data=%h ce=%0d", last_wdata, ce_cnt);
    endtask

    task automatic test_hazard();
        int w0;
        bit seen;
        apply_reset(16'd0);
        poke(7, 8'hB5);
        release_reset();
        w0 = scrub_writes;
        seen = 1'b0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge clk);
            if (bus.o_mem_en && !bus.o_mem_we && !bus.i_host_req && bus.o_mem_addr == 6'd7) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL hazard_read7: seen=%0b expected 1", seen);
        end
        @(posedge clk); #1;
        bus.i_host_req   = 1'b1;
        bus.i_host_we    = 1'b1;
        bus.i_host_addr  = 6'd7;
        bus.i_host_wdata = 8'hCC;
        @(posedge clk); #1;
        bus.i_host_req   = 1'b0;
        bus.i_host_we    = 1'b0;
        wait_pass(2000);
        checks++;
        if (mem[7] !== 8'hCC || scrub_writes != w0) begin
            errors++;
            $display("FAIL hazard_host_wins: word7=%h writes=%0d expected cc 0", mem[7], scrub_writes - w0);
        end
        checks++;
        if (ce_cnt !== 8'd0) begin
            errors++;
            $display("FAIL hazard_ce_cnt: got %0d expected 0", ce_cnt);
        end
        $display("test_hazard: word7=%h ce=%0d", mem[7], ce_cnt);
    endtask

    initial begin
        rst              = 1'b1;
        scrub_en         = 1'b0;
        interval         = '0;
        bus.i_host_req   = 1'b0;
        bus.i_host_we    = 1'b0;
        bus.i_host_addr  = '0;
        bus.i_host_wdata = '0;
        test_reset();
        test_clean_pass();
        test_single_ce();
        test_double_ue();
        test_overall_parity();
        test_host_stall();
        test_hazard();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
